iir_stream_checker: RTL
=======================

Name: iir_stream_checker

Overview:
- Parametrised, synthesizable successor to the filter bench's data sink.
- Buffers a golden expected-sample stream in an internal FIFO.
- Compares each DUT output sample against the buffered stream with a programmable tolerance, tracks errors per interleaved channel, and raises done/end_sim after a programmed sample count.
- Sits beside the filter under test: expected stream from the golden-model side, DUT stream from the filter's dOut/vOut.

Parameters:
NB, 12, sample width (two's complement)
NCH, 1, number of round-robin interleaved channels (1..16)
DEPTH, 16, expected-sample FIFO depth (power of 2, >=2)
TOL, 0, max allowed |dIn - expected| before a mismatch
TIMEOUT, 1024, watchdog limit in cycles (used only with macro)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  arm/re-arm checker (1-cycle pulse)
n_samples  in  16  number of DUT samples to compare, sampled on start
vExp  in  1  expected sample valid
dExp  in  NB  expected sample
vIn  in  1  DUT output valid
dIn  in  NB  DUT output sample
busy  out  1  high in RUN
mismatch  out  1  1-cycle pulse per failed compare
err_cnt  out  16  total mismatches, saturating
ch_err  out  NCH  sticky per-channel mismatch flags
overflow  out  1  sticky: expected sample dropped on full FIFO
underflow  out  1  sticky: DUT sample arrived with no expected sample
done  out  1  high in DONE
end_sim  out  1  high in DONE (drives bench stop)

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO empty, all outputs 0, all counters 0.
- FSM IDLE -> RUN on start. On start: clear FIFO, err_cnt, ch_err, overflow, underflow, compare counter, channel index; latch n_samples.
- start with latched n_samples=0 -> DONE next cycle.
- RUN -> DONE at the edge on which the compare counter reaches n_samples.
- DONE -> RUN on start, with the same clears. start in RUN is ignored.
- IDLE/DONE: vExp and vIn ignored; no push, no pop, no flag updates.
- Push: vExp in RUN. Pop/compare: vIn in RUN.
- Full FIFO, push+pop same cycle: both happen, no overflow. Full FIFO, push without pop: sample dropped, overflow=1.
- Empty FIFO, vIn with same-cycle vExp: bypass, compare against dExp, nothing stored, no underflow.
- Empty FIFO, vIn without vExp: underflow=1, counted as mismatch on the current channel, compare counter advances.
- Compare: sign-extend both samples to NB+1 bits, take |difference|; mismatch if > TOL.
- Results registered, visible 1 cycle after the vIn cycle: mismatch pulse, err_cnt+1 (holds at 0xFFFF), ch_err[ch]=1.
- Channel index advances on every compare and wraps NCH-1 -> 0. With NCH=1 it stays 0.
- done/end_sim go high in the same cycle as the last compare's result and hold until start or rst.
- Reset mid-run aborts immediately to IDLE; all state cleared.

Optional Feature:
- Macro: CHECK_TIMEOUT_EN.
- Defined: adds output `timeout` (1 bit, sticky, reset 0). Watchdog counter clears on every vIn and on start. It counts in RUN only while the FIFO is non-empty. When it reaches TIMEOUT: timeout=1, FSM -> DONE next edge.
- Undefined: no port, no counter; RUN is left only by reaching n_samples.

Decomposition:
- Package iir_tb_pkg: sample-width default NB, counter width CNT_W=16, FSM state enum (IDLE, RUN, DONE), err_cnt saturation constant.
- Sub-module sync_fifo (DEPTH, NB): push/pop/full/empty, pointers one bit wider than log2(DEPTH).
- The checker holds the FSM, bypass, compare, counters and flags.

Test Plan:
- NCH=1, TOL=0, n_samples=8, expected = dIn = 0..7 -> mismatch never pulses, err_cnt=0, done/end_sim high 1 cycle after the 8th vIn.
- TOL=2, expected 100, dIn 102 then 97 -> first passes; second pulses mismatch, err_cnt=1.
- NCH=4, 8 samples, only the 7th wrong -> ch_err=4'b0100, err_cnt=1.
- DEPTH=4, 5 vExp without vIn -> overflow=1 on 5th. Then vIn on empty FIFO without vExp -> underflow=1, err_cnt+1. Bypass case (empty FIFO, vIn+vExp same cycle, equal values) -> no flags.
- Assert rst mid-RUN with err_cnt=3 -> all outputs 0 immediately. start with n_samples=0 -> done next cycle.
- CHECK_TIMEOUT_EN, TIMEOUT=10, one vExp, no vIn -> timeout=1 after 10 cycles, then done=1.

Source files
------------

// File: rtl/iir_tb_pkg.sv
// Shared types and constants for the IIR stream checker.
package iir_tb_pkg;

    // Default sample width of the filter under test.
    localparam int NB_DEF = 12;

    // Width of the sample and error counters.
    localparam int CNT_W = 16;

    // Value at which the error counter stops incrementing.
    localparam logic [CNT_W-1:0] ERR_SAT = 16'hFFFF;

    // Checker FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
// The clr input empties the FIFO on the next edge; it has priority over push/pop.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int NB    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [NB-1:0] din,
    output logic [NB-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [NB-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign dout   = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update: clear on request, otherwise advance on accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (w_push && !clr) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/iir_stream_checker.sv
// Stream checker: buffers the golden expected stream, compares each DUT
// sample within a tolerance, tracks per-channel errors and signals done.
// Optional watchdog enabled with macro CHECK_TIMEOUT_EN (adds port timeout).
module iir_stream_checker
    import iir_tb_pkg::*;
#(
    parameter int NB      = NB_DEF,
    parameter int NCH     = 1,
    parameter int DEPTH   = 16,
    parameter int TOL     = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      n_samples,
    input  logic             vExp,
    input  logic [NB-1:0]    dExp,
    input  logic             vIn,
    input  logic [NB-1:0]    dIn,
    output logic             busy,
    output logic             mismatch,
    output logic [15:0]      err_cnt,
    output logic [NCH-1:0]   ch_err,
    output logic             overflow,
    output logic             underflow,
`ifdef CHECK_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic             done,
    output logic             end_sim
);

    localparam int          CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [NB:0] TOL_V = (NB+1)'(TOL);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_mismatch;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [NCH-1:0]    r_ch_err;
    logic              r_overflow;
    logic              r_underflow;
    logic [CNT_W-1:0]  r_n_samples;
    logic [CNT_W-1:0]  r_cmp_cnt;
    logic [CH_W-1:0]   r_ch;

    logic              w_run;
    logic              w_clr;
    logic              w_full;
    logic              w_empty;
    logic [NB-1:0]     w_fifo_dout;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf;
    logic              w_unf;
    logic [NB-1:0]     w_exp_s;
    logic [NB:0]       w_diff;
    logic [NB:0]       w_abs;
    logic              w_bad;
    logic [CNT_W-1:0]  w_cnt_nxt;

`ifdef CHECK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]   r_wd;
    logic              r_timeout;
    assign timeout = r_timeout;
`endif

    assign w_run     = (r_state == ST_RUN);
    assign w_clr     = start && !w_run;
    // Empty FIFO with both streams valid: compare straight against dExp.
    assign w_bypass  = w_run && vIn && vExp && w_empty;
    // On a full FIFO a push is only accepted when a pop frees a slot.
    assign w_push    = w_run && vExp && !w_bypass && (!w_full || vIn);
    assign w_pop     = w_run && vIn && !w_empty;
    assign w_ovf     = w_run && vExp && w_full && !vIn;
    assign w_unf     = w_run && vIn && w_empty && !vExp;
    assign w_exp_s   = w_empty ? dExp : w_fifo_dout;
    // Sign-extend to NB+1 bits so the difference can never overflow.
    assign w_diff    = {dIn[NB-1], dIn} - {w_exp_s[NB-1], w_exp_s};
    assign w_abs     = w_diff[NB] ? (-w_diff) : w_diff;
    assign w_bad     = w_unf || (w_abs > TOL_V);
    assign w_cnt_nxt = r_cmp_cnt + 16'd1;

    sync_fifo #(
        .DEPTH (DEPTH),
        .NB    (NB)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .push  (w_push),
        .pop   (w_pop),
        .din   (dExp),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Checker FSM with registered result pulses, counters and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_cnt   <= '0;
            r_ch_err    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_n_samples <= '0;
            r_cmp_cnt   <= '0;
            r_ch        <= '0;
`ifdef CHECK_TIMEOUT_EN
            r_wd        <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_mismatch <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_err_cnt   <= '0;
                        r_ch_err    <= '0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_cmp_cnt   <= '0;
                        r_ch        <= '0;
                        r_n_samples <= n_samples;
`ifdef CHECK_TIMEOUT_EN
                        r_wd        <= '0;
                        r_timeout   <= 1'b0;
`endif
                        if (n_samples == 16'd0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_ovf) r_overflow <= 1'b1;
`ifdef CHECK_TIMEOUT_EN
                    if (vIn) begin
                        r_wd <= '0;
                    end else if (!w_empty) begin
                        if (r_wd == WD_W'(TIMEOUT)) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
`endif
                    if (vIn) begin
                        if (w_unf) r_underflow <= 1'b1;
                        r_cmp_cnt <= w_cnt_nxt;
                        if (r_ch == CH_W'(NCH - 1)) r_ch <= '0;
                        else                        r_ch <= r_ch + 1'b1;
                        if (w_bad) begin
                            r_mismatch     <= 1'b1;
                            r_ch_err[r_ch] <= 1'b1;
                            if (r_err_cnt != ERR_SAT) r_err_cnt <= r_err_cnt + 16'd1;
                        end
                        if (w_cnt_nxt == r_n_samples) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign end_sim   = r_done;
    assign mismatch  = r_mismatch;
    assign err_cnt   = r_err_cnt;
    assign ch_err    = r_ch_err;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
